// File: rtl/mem_bus_pkg.sv
// Shared types and idle pin levels for the external memory bus sequencer.
package mem_bus_pkg;

    typedef enum logic [2:0] {
        LATCH = 3'd0,
        ALO   = 3'd1,
        AHI   = 3'd2,
        DATA  = 3'd3,
        ACK   = 3'd4
    } mem_state_t;

    localparam logic PIN_WE_IDLE = 1'b1;
    localparam logic BUS_OE_IDLE = 1'b0;

endpackage

// File: rtl/bus_wait_timer.sv
// Loadable down-counter with saturating decrement and terminal-count (zero) flag.
module bus_wait_timer #(
    parameter int WCNT_W = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load,
    input  logic [WCNT_W-1:0] load_val,
    input  logic              dec,
    output logic              zero
);

    logic [WCNT_W-1:0] cnt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (dec && (cnt != '0)) begin
            cnt <= cnt - 1'b1;
        end
    end

    assign zero = (cnt == '0);

endmodule

// File: rtl/mem_bus_sequencer.sv
// Serialises 6502 address/data/we onto a pin-limited external bus, stalling the
// core via cpu_rdy until each access completes.
//
// state | meaning
// LATCH | capture cpu_ab/cpu_we/cpu_do, load wait timer, core stalled
// ALO   | drive address low byte, pulse pin_ale_lo
// AHI   | drive address high byte, pulse pin_ale_hi
// DATA  | write: drive data bus + pin_we_n low; read: sample bus_in on exit
// ACK   | cpu_rdy high for one cycle
module mem_bus_sequencer
    import mem_bus_pkg::*;
#(
    parameter int WAIT_CYCLES = 0,
    parameter int WCNT_W      = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] cpu_ab,
    input  logic        cpu_we,
    input  logic [7:0]  cpu_do,
    output logic [7:0]  cpu_di,
    output logic        cpu_rdy,
    output logic [7:0]  pin_out,
    output logic        pin_ale_lo,
    output logic        pin_ale_hi,
    output logic        pin_we_n,
    output logic [7:0]  bus_out,
    output logic        bus_oe,
    input  logic [7:0]  bus_in,
    input  logic        ext_wait
);

    localparam logic [WCNT_W-1:0] WAIT_LOAD = WCNT_W'(WAIT_CYCLES);

    mem_state_t  state;
    mem_state_t  state_nxt;
    logic [15:0] addr_q;
    logic        we_q;
    logic [7:0]  do_q;
    logic [7:0]  cpu_di_q;
    logic        wait_zero;
    logic        data_done;
    logic        write_drive;

    // ext_wait only matters here; it is never looked at outside DATA
    assign data_done = (state == DATA) && wait_zero && !ext_wait;

    bus_wait_timer #(
        .WCNT_W (WCNT_W)
    ) u_wait_timer (
        .clk      (clk),
        .reset    (reset),
        .load     (state == LATCH),
        .load_val (WAIT_LOAD),
        .dec      ((state == DATA) && !data_done),
        .zero     (wait_zero)
    );

    always_comb begin
        state_nxt = state;
        case (state)
            LATCH:   state_nxt = ALO;
            ALO:     state_nxt = AHI;
            AHI:     state_nxt = DATA;
            DATA:    if (data_done) state_nxt = ACK;
            ACK:     state_nxt = LATCH;
            default: state_nxt = LATCH;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= LATCH;
            addr_q   <= '0;
            we_q     <= 1'b0;
            do_q     <= '0;
            cpu_di_q <= '0;
        end else begin
            state <= state_nxt;
            if (state == LATCH) begin
                addr_q <= cpu_ab;
                we_q   <= cpu_we;
                do_q   <= cpu_do;
            end
            if (data_done && !we_q) begin
                cpu_di_q <= bus_in;
            end
        end
    end

    // Outside ALO the high byte stays parked on the pins, so no extra register is needed
    assign pin_out     = (state == ALO) ? addr_q[7:0] : addr_q[15:8];
    assign pin_ale_lo  = (state == ALO);
    assign pin_ale_hi  = (state == AHI);
    assign write_drive = (state == DATA) && we_q;
    assign pin_we_n    = write_drive ? 1'b0 : PIN_WE_IDLE;
    assign bus_oe      = write_drive ? 1'b1 : BUS_OE_IDLE;
    assign bus_out     = do_q;
    assign cpu_rdy     = (state == ACK);
    assign cpu_di      = cpu_di_q;

endmodule

// File: tb/tb_mem_bus_sequencer.sv
// Bench for mem_bus_sequencer: directed cycle table, hand sequences and a
// randomized run checked against an access-level reference model.
module tb_mem_bus_sequencer;

    typedef struct packed {
        logic [7:0] pin;
        logic       lo;
        logic       hi;
        logic       wen;
        logic       oe;
        logic [7:0] bus;
        logic       rdy;
        logic [7:0] di;
    } out_t;

    typedef struct packed {
        logic        rst;
        logic [15:0] ab;
        logic        we;
        logic [7:0]  d;
        logic [7:0]  bin;
        logic        ew;
        out_t        exp;
    } vec_t;

    // ph counts the cycles of one access: 0 capture, 1 addr lo, 2 addr hi, 3 data, 4 ack
    typedef struct packed {
        logic [2:0]  ph;
        logic [15:0] addr;
        logic        we;
        logic [7:0]  dout;
        logic [7:0]  di;
        logic [7:0]  ndata;
    } model_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [15:0] cpu_ab = '0;
    logic        cpu_we = 1'b0;
    logic [7:0]  cpu_do = '0;
    logic [7:0]  bus_in = '0;
    logic        ext_wait = 1'b0;

    logic [7:0] di0, pin0, bus0, di3, pin3, bus3;
    logic       rdy0, lo0, hi0, wen0, oe0, rdy3, lo3, hi3, wen3, oe3;

    int n_vec = 0;
    int n_bad = 0;
    vec_t   vecs[$];
    model_t m0, m3;

    always #5 clk = ~clk;

    mem_bus_sequencer #(.WAIT_CYCLES(0), .WCNT_W(4)) u_dut0 (
        .clk(clk), .reset(reset), .cpu_ab(cpu_ab), .cpu_we(cpu_we), .cpu_do(cpu_do),
        .cpu_di(di0), .cpu_rdy(rdy0), .pin_out(pin0), .pin_ale_lo(lo0), .pin_ale_hi(hi0),
        .pin_we_n(wen0), .bus_out(bus0), .bus_oe(oe0), .bus_in(bus_in), .ext_wait(ext_wait)
    );

    mem_bus_sequencer #(.WAIT_CYCLES(3), .WCNT_W(4)) u_dut3 (
        .clk(clk), .reset(reset), .cpu_ab(cpu_ab), .cpu_we(cpu_we), .cpu_do(cpu_do),
        .cpu_di(di3), .cpu_rdy(rdy3), .pin_out(pin3), .pin_ale_lo(lo3), .pin_ale_hi(hi3),
        .pin_we_n(wen3), .bus_out(bus3), .bus_oe(oe3), .bus_in(bus_in), .ext_wait(ext_wait)
    );

    function automatic model_t model_next(model_t c, int w, logic [15:0] ab, logic we,
                                          logic [7:0] d, logic [7:0] bin, logic ew);
        model_t n = c;
        case (c.ph)
            3'd0: begin n.addr = ab; n.we = we; n.dout = d; n.ph = 3'd1; end
            3'd1: n.ph = 3'd2;
            3'd2: begin n.ph = 3'd3; n.ndata = 8'd0; end
            3'd3: begin
                if (int'(c.ndata) >= w && !ew) begin
                    if (!c.we) n.di = bin;
                    n.ph = 3'd4;
                end else if (c.ndata != 8'hFF) begin
                    n.ndata = c.ndata + 8'd1;
                end
            end
            default: n.ph = 3'd0;
        endcase
        return n;
    endfunction

    function automatic out_t model_exp(model_t c);
        out_t o;
        o.pin = (c.ph == 3'd1) ? c.addr[7:0] : c.addr[15:8];
        o.lo  = (c.ph == 3'd1);
        o.hi  = (c.ph == 3'd2);
        o.oe  = (c.ph == 3'd3) && c.we;
        o.wen = !o.oe;
        o.bus = o.oe ? c.dout : 8'h00;
        o.rdy = (c.ph == 3'd4);
        o.di  = c.di;
        return o;
    endfunction

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m0 <= '0;
            m3 <= '0;
        end else begin
            m0 <= model_next(m0, 0, cpu_ab, cpu_we, cpu_do, bus_in, ext_wait);
            m3 <= model_next(m3, 3, cpu_ab, cpu_we, cpu_do, bus_in, ext_wait);
        end
    end

    function automatic out_t got0();
        return '{pin: pin0, lo: lo0, hi: hi0, wen: wen0, oe: oe0, bus: bus0, rdy: rdy0, di: di0};
    endfunction

    function automatic out_t got3();
        return '{pin: pin3, lo: lo3, hi: hi3, wen: wen3, oe: oe3, bus: bus3, rdy: rdy3, di: di3};
    endfunction

    // bus_out is only defined while the bus is driven
    task automatic check(string name, out_t got, out_t exp);
        n_vec++;
        if (!exp.oe) got.bus = 8'h00;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s t=%0t got pin=%h lo=%b hi=%b we_n=%b oe=%b bus=%h rdy=%b di=%h | want pin=%h lo=%b hi=%b we_n=%b oe=%b bus=%h rdy=%b di=%h",
                     name, $time, got.pin, got.lo, got.hi, got.wen, got.oe, got.bus, got.rdy, got.di,
                     exp.pin, exp.lo, exp.hi, exp.wen, exp.oe, exp.bus, exp.rdy, exp.di);
        end
    endtask

    task automatic add(logic rst, logic [15:0] ab, logic we, logic [7:0] d, logic [7:0] bin,
                       logic ew, logic [7:0] pin, logic lo, logic hi, logic oe,
                       logic [7:0] bus, logic rdy, logic [7:0] di);
        vec_t v;
        v.rst = rst; v.ab = ab; v.we = we; v.d = d; v.bin = bin; v.ew = ew;
        v.exp = '{pin: pin, lo: lo, hi: hi, wen: !oe, oe: oe, bus: bus, rdy: rdy, di: di};
        vecs.push_back(v);
    endtask

    initial begin
        // inputs of row i are captured at the edge ending row i; expectations are row i's outputs
        add(1, 16'h1234, 0, 8'h00, 8'hA5, 0,  8'h00, 0, 0, 0, 8'h00, 0, 8'h00);
        add(0, 16'h1234, 0, 8'h00, 8'hA5, 0,  8'h00, 0, 0, 0, 8'h00, 0, 8'h00);
        add(0, 16'h1234, 0, 8'h00, 8'hA5, 0,  8'h34, 1, 0, 0, 8'h00, 0, 8'h00);
        add(0, 16'h1234, 0, 8'h00, 8'hA5, 0,  8'h12, 0, 1, 0, 8'h00, 0, 8'h00);
        add(0, 16'h1234, 0, 8'h00, 8'hA5, 0,  8'h12, 0, 0, 0, 8'h00, 0, 8'h00);
        add(0, 16'hFFFF, 1, 8'h5A, 8'h00, 0,  8'h12, 0, 0, 0, 8'h00, 1, 8'hA5);
        add(0, 16'hFFFF, 1, 8'h5A, 8'h00, 0,  8'h12, 0, 0, 0, 8'h00, 0, 8'hA5);
        add(0, 16'hFFFF, 1, 8'h5A, 8'h00, 0,  8'hFF, 1, 0, 0, 8'h00, 0, 8'hA5);
        add(0, 16'hFFFF, 1, 8'h5A, 8'h00, 0,  8'hFF, 0, 1, 0, 8'h00, 0, 8'hA5);
        add(0, 16'hFFFF, 1, 8'h5A, 8'h00, 0,  8'hFF, 0, 0, 1, 8'h5A, 0, 8'hA5);
        add(0, 16'h0001, 0, 8'h00, 8'h11, 0,  8'hFF, 0, 0, 0, 8'h00, 1, 8'hA5);
        add(0, 16'h0001, 0, 8'h00, 8'h11, 0,  8'hFF, 0, 0, 0, 8'h00, 0, 8'hA5);
        add(0, 16'h0001, 0, 8'h00, 8'h11, 0,  8'h01, 1, 0, 0, 8'h00, 0, 8'hA5);
        add(0, 16'h0001, 0, 8'h00, 8'h11, 0,  8'h00, 0, 1, 0, 8'h00, 0, 8'hA5);
        add(0, 16'h0001, 0, 8'h00, 8'h11, 0,  8'h00, 0, 0, 0, 8'h00, 0, 8'hA5);
        add(0, 16'h0002, 0, 8'h00, 8'h22, 0,  8'h00, 0, 0, 0, 8'h00, 1, 8'h11);
        add(0, 16'h0002, 0, 8'h00, 8'h22, 0,  8'h00, 0, 0, 0, 8'h00, 0, 8'h11);
        add(0, 16'h0002, 0, 8'h00, 8'h22, 0,  8'h02, 1, 0, 0, 8'h00, 0, 8'h11);
        add(0, 16'h0002, 0, 8'h00, 8'h22, 0,  8'h00, 0, 1, 0, 8'h00, 0, 8'h11);
        add(0, 16'h0002, 0, 8'h00, 8'h22, 0,  8'h00, 0, 0, 0, 8'h00, 0, 8'h11);
        add(0, 16'h4321, 0, 8'h00, 8'h77, 0,  8'h00, 0, 0, 0, 8'h00, 1, 8'h22);
        add(0, 16'h4321, 0, 8'h00, 8'h77, 0,  8'h00, 0, 0, 0, 8'h00, 0, 8'h22);
        add(0, 16'h4321, 0, 8'h00, 8'h77, 1,  8'h21, 1, 0, 0, 8'h00, 0, 8'h22);
        add(0, 16'h4321, 0, 8'h00, 8'h77, 1,  8'h43, 0, 1, 0, 8'h00, 0, 8'h22);
        for (int i = 0; i < 6; i++)
            add(0, 16'h4321, 0, 8'h00, 8'h77, 1, 8'h43, 0, 0, 0, 8'h00, 0, 8'h22);
        add(0, 16'h4321, 0, 8'h00, 8'h77, 0,  8'h43, 0, 0, 0, 8'h00, 0, 8'h22);
        add(0, 16'hBEEF, 1, 8'hC3, 8'h00, 0,  8'h43, 0, 0, 0, 8'h00, 1, 8'h77);
        add(0, 16'hBEEF, 1, 8'hC3, 8'h00, 0,  8'h43, 0, 0, 0, 8'h00, 0, 8'h77);
        add(0, 16'hBEEF, 1, 8'hC3, 8'h00, 0,  8'hEF, 1, 0, 0, 8'h00, 0, 8'h77);
        add(0, 16'hBEEF, 1, 8'hC3, 8'h00, 0,  8'hBE, 0, 1, 0, 8'h00, 0, 8'h77);
        add(0, 16'hBEEF, 1, 8'hC3, 8'h00, 0,  8'hBE, 0, 0, 1, 8'hC3, 0, 8'h77);
        add(1, 16'h5678, 0, 8'h00, 8'h99, 0,  8'h00, 0, 0, 0, 8'h00, 0, 8'h00);
        add(0, 16'h5678, 0, 8'h00, 8'h99, 0,  8'h00, 0, 0, 0, 8'h00, 0, 8'h00);
        add(0, 16'h5678, 0, 8'h00, 8'h99, 0,  8'h78, 1, 0, 0, 8'h00, 0, 8'h00);
        add(0, 16'h5678, 0, 8'h00, 8'h99, 0,  8'h56, 0, 1, 0, 8'h00, 0, 8'h00);
        add(0, 16'h5678, 0, 8'h00, 8'h99, 0,  8'h56, 0, 0, 0, 8'h00, 0, 8'h00);
        add(0, 16'h5678, 0, 8'h00, 8'h99, 0,  8'h56, 0, 0, 0, 8'h00, 1, 8'h99);
        add(0, 16'h5678, 0, 8'h00, 8'h99, 0,  8'h56, 0, 0, 0, 8'h00, 0, 8'h99);

        repeat (2) @(posedge clk);

        foreach (vecs[i]) begin
            @(negedge clk);
            reset = vecs[i].rst; cpu_ab = vecs[i].ab; cpu_we = vecs[i].we;
            cpu_do = vecs[i].d; bus_in = vecs[i].bin; ext_wait = vecs[i].ew;
            #1;
            check($sformatf("table_w0[%0d]", i), got0(), vecs[i].exp);
        end

        // WAIT_CYCLES=3 read of 16'h00FF: DATA spans cycles 4..7, ACK at cycle 8
        @(negedge clk);
        reset = 1'b1; cpu_ab = 16'h00FF; cpu_we = 1'b0; cpu_do = 8'h00; ext_wait = 1'b0;
        for (int c = 1; c <= 9; c++) begin
            out_t e;
            @(negedge clk);
            reset = 1'b0;
            bus_in = 8'h40 + 8'(c);
            #1;
            e.pin = (c == 2) ? 8'hFF : 8'h00;
            e.lo  = (c == 2);
            e.hi  = (c == 3);
            e.oe  = 1'b0;
            e.wen = 1'b1;
            e.bus = 8'h00;
            e.rdy = (c == 8);
            e.di  = (c >= 8) ? 8'h47 : 8'h00;
            if (c == 1) e.pin = 8'h00;
            check($sformatf("wait3_read_c%0d", c), got3(), e);
        end

        for (int i = 0; i < 1500; i++) begin
            @(negedge clk);
            reset    = ($urandom_range(0, 99) == 0);
            cpu_ab   = 16'($urandom);
            cpu_we   = 1'($urandom);
            cpu_do   = 8'($urandom);
            bus_in   = 8'($urandom);
            ext_wait = ($urandom_range(0, 3) == 0);
            #1;
            check("rand_w0", got0(), model_exp(m0));
            check("rand_w3", got3(), model_exp(m3));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
